// File: rtl/demux_1x3_hs_pkg.sv
// rtl/demux_1x3_hs_pkg.sv - shared constants and types for the 1-to-3 handshake demux
//
// Purpose: channel-select encodings (shared with the 3:1 operand selector),
// the default data width, and the per-slot state type.
// Ports: none (package).
package demux_1x3_hs_pkg;

    localparam int DEF_W = 23;

    localparam logic [1:0] CH_S0  = 2'b00;
    localparam logic [1:0] CH_S1  = 2'b01;
    localparam logic [1:0] CH_S2  = 2'b10;
    localparam logic [1:0] CH_INV = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_1x3_hs_out_slot.sv
// rtl/demux_1x3_hs_out_slot.sv - one-entry registered output slot with valid/ready
//
// Purpose: holds one word for a consumer. It loads on load, drains on ready
// while full, and allows a simultaneous drain and load for full throughput.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            write din into the slot this cycle
//   din [W-1:0]     data to store
//   ready           consumer takes dout this cycle (ignored while empty)
//   dout [W-1:0]    held data (keeps last value after a drain)
//   valid           slot holds valid data
//   can_load        slot is empty or draining this cycle
module out_slot
    import demux_1x3_hs_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         can_load
);

    slot_state_e  state_q, state_d;
    logic [W-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A load always wins over a drain, so drain+load keeps the slot full.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_EMPTY: if (load)           state_d = SLOT_FULL;
            SLOT_FULL:  if (ready && !load) state_d = SLOT_EMPTY;
            default:                        state_d = SLOT_EMPTY;
        endcase
    end

    // Data only changes on a load, which gives the stable-data rule for free.
    always_comb begin
        data_d = data_q;
        if (load) data_d = din;
    end

    always_comb begin
        valid    = (state_q == SLOT_FULL);
        can_load = (state_q == SLOT_EMPTY) || ready;
    end

    assign dout = data_q;

endmodule

// File: rtl/demux_1x3_hs.sv
// rtl/demux_1x3_hs.sv - registered 1-to-3 demultiplexer with valid/ready handshake
//
// Purpose: routes one producer word to one of three one-entry output slots by
// ctrl; ctrl=11 transfers are accepted, discarded, flagged on err and counted.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   ctrl [1:0]            destination select (00/01/10 -> S0/S1/S2, 11 invalid)
//   in_valid, in_ready    producer handshake
//   D [W-1:0]             input data
//   S0, S1, S2 [W-1:0]    per-channel registered data
//   out_valid [2:0]       per-channel valid
//   out_ready [2:0]       per-channel consumer ready
//   err                   one-cycle pulse after a dropped (ctrl=11) transfer
//   drop_cnt [DROP_W-1:0] saturating count of dropped transfers
module demux_1x3_hs
    import demux_1x3_hs_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ctrl,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      D,
    output logic [W-1:0]      S0,
    output logic [W-1:0]      S1,
    output logic [W-1:0]      S2,
    output logic [2:0]        out_valid,
    input  logic [2:0]        out_ready,
    output logic              err,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [2:0]   load;
    logic [2:0]   can_load;
    logic [W-1:0] slot_data [3];
    logic         acc;
    logic         drop;

    logic              err_q, err_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    // in_ready depends only on the addressed slot, so a stalled channel never
    // blocks traffic to the others; invalid selects are always sunk.
    always_comb begin
        in_ready = 1'b1;
        unique case (ctrl)
            CH_S0:   in_ready = can_load[0];
            CH_S1:   in_ready = can_load[1];
            CH_S2:   in_ready = can_load[2];
            default: in_ready = 1'b1;
        endcase
    end

    assign acc  = in_valid && in_ready;
    assign drop = acc && (ctrl == CH_INV);

    always_comb begin
        load = 3'b000;
        if (acc) begin
            unique case (ctrl)
                CH_S0:   load = 3'b001;
                CH_S1:   load = 3'b010;
                CH_S2:   load = 3'b100;
                default: load = 3'b000;
            endcase
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_slot
        out_slot #(.W(W)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[i]),
            .din      (D),
            .ready    (out_ready[i]),
            .dout     (slot_data[i]),
            .valid    (out_valid[i]),
            .can_load (can_load[i])
        );
    end

    assign S0 = slot_data[0];
    assign S1 = slot_data[1];
    assign S2 = slot_data[2];

    always_comb begin
        err_d      = drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign err      = err_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_1x3_hs.sv
// tb/tb_demux_1x3_hs.sv - self-checking bench for demux_1x3_hs
module tb_demux_1x3_hs;

    localparam int W      = 23;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        ctrl;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      D;
    logic [W-1:0]      S0, S1, S2;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;
    logic              err;
    logic [DROP_W-1:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    demux_1x3_hs #(.W(W), .DROP_W(DROP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl      (ctrl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .S0        (S0),
        .S1        (S1),
        .S2        (S2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .drop_cnt  (drop_cnt)
    );

    typedef struct {
        logic [1:0]   ctrl;
        logic         vld;
        logic [W-1:0] d;
        logic [2:0]   ordy;
        logic         exp_ir;
        logic [2:0]   exp_ov;
        logic [W-1:0] exp_s0;
        logic [W-1:0] exp_s1;
        logic [W-1:0] exp_s2;
        logic         exp_err;
        logic [7:0]   exp_cnt;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] c, input logic v, input logic [W-1:0] d,
                                input logic [2:0] o, input logic ir, input logic [2:0] ov,
                                input logic [W-1:0] s0, input logic [W-1:0] s1,
                                input logic [W-1:0] s2, input logic e, input logic [7:0] cnt);
        vec_t r;
        r.ctrl = c; r.vld = v; r.d = d; r.ordy = o; r.exp_ir = ir; r.exp_ov = ov;
        r.exp_s0 = s0; r.exp_s1 = s1; r.exp_s2 = s2; r.exp_err = e; r.exp_cnt = cnt;
        return r;
    endfunction

    initial begin
        int model_cnt;
        int err_pulses;

        //            ctrl  vld D          ordy    ir  ov      S0         S1         S2        err cnt
        vecs[0]  = mk(2'd1, 1, 23'h2AAAAA, 3'b111, 1, 3'b010, 23'h0,     23'h2AAAAA, 23'h0,    0, 0);
        vecs[1]  = mk(2'd0, 0, 23'h0,      3'b111, 1, 3'b000, 23'h0,     23'h2AAAAA, 23'h0,    0, 0);
        vecs[2]  = mk(2'd0, 1, 23'h1,      3'b110, 1, 3'b001, 23'h1,     23'h2AAAAA, 23'h0,    0, 0);
        vecs[3]  = mk(2'd0, 1, 23'h2,      3'b110, 0, 3'b001, 23'h1,     23'h2AAAAA, 23'h0,    0, 0);
        vecs[4]  = mk(2'd0, 1, 23'h2,      3'b110, 0, 3'b001, 23'h1,     23'h2AAAAA, 23'h0,    0, 0);
        vecs[5]  = mk(2'd0, 1, 23'h2,      3'b111, 1, 3'b001, 23'h2,     23'h2AAAAA, 23'h0,    0, 0);
        vecs[6]  = mk(2'd1, 1, 23'h7FFFFF, 3'b110, 1, 3'b011, 23'h2,     23'h7FFFFF, 23'h0,    0, 0);
        vecs[7]  = mk(2'd3, 1, 23'h123,    3'b000, 1, 3'b011, 23'h2,     23'h7FFFFF, 23'h0,    1, 1);
        vecs[8]  = mk(2'd3, 0, 23'h0,      3'b000, 1, 3'b011, 23'h2,     23'h7FFFFF, 23'h0,    0, 1);
        vecs[9]  = mk(2'd2, 1, 23'h55,     3'b000, 1, 3'b111, 23'h2,     23'h7FFFFF, 23'h55,   0, 1);
        vecs[10] = mk(2'd1, 0, 23'h0,      3'b010, 1, 3'b101, 23'h2,     23'h7FFFFF, 23'h55,   0, 1);
        vecs[11] = mk(2'd0, 0, 23'h0,      3'b001, 1, 3'b100, 23'h2,     23'h7FFFFF, 23'h55,   0, 1);
        vecs[12] = mk(2'd2, 0, 23'h0,      3'b100, 1, 3'b000, 23'h2,     23'h7FFFFF, 23'h55,   0, 1);

        rst = 1'b1; ctrl = 2'd0; in_valid = 1'b0; D = '0; out_ready = 3'b000;
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_s0", 32'(S0), 32'd0);
        chk("reset_s1", 32'(S1), 32'd0);
        chk("reset_s2", 32'(S2), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        for (int c = 0; c < 4; c++) begin
            ctrl = 2'(c);
            #1;
            chk("reset_in_ready", 32'(in_ready), 32'd1);
        end
        tick();
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            ctrl = vecs[i].ctrl; in_valid = vecs[i].vld; D = vecs[i].d; out_ready = vecs[i].ordy;
            #2;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
            tick();
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            chk($sformatf("v%0d_s0", i), 32'(S0), 32'(vecs[i].exp_s0));
            chk($sformatf("v%0d_s1", i), 32'(S1), 32'(vecs[i].exp_s1));
            chk($sformatf("v%0d_s2", i), 32'(S2), 32'(vecs[i].exp_s2));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].exp_cnt));
        end

        // Streaming: ch2 every cycle, consumer always ready, no bubbles.
        ctrl = 2'd2; in_valid = 1'b1; out_ready = 3'b100;
        for (int i = 0; i < 10; i++) begin
            D = 23'(i);
            #2;
            chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("stream%0d_s2", i), 32'(S2), 32'(i));
            chk($sformatf("stream%0d_ov", i), 32'(out_valid), 32'b100);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained_ov", 32'(out_valid), 32'd0);

        // Invalid selects: 260 drops, err pulses each one, count saturates.
        model_cnt  = 1;
        err_pulses = 0;
        ctrl = 2'd3; in_valid = 1'b1; out_ready = 3'b000;
        for (int i = 0; i < 260; i++) begin
            D = 23'(i);
            tick();
            if (err === 1'b1) err_pulses++;
            model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
            chk($sformatf("drop%0d_cnt", i), 32'(drop_cnt), 32'(model_cnt));
        end
        in_valid = 1'b0;
        chk("drop_err_pulses", 32'(err_pulses), 32'd260);
        chk("drop_final_cnt", 32'(drop_cnt), 32'd255);
        chk("drop_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("drop_err_cleared", 32'(err), 32'd0);

        // Fill all three channels with the consumers stalled, then reset mid-cycle.
        in_valid = 1'b1; out_ready = 3'b000;
        for (int c = 0; c < 3; c++) begin
            ctrl = 2'(c);
            D = 23'h100 + 23'(c);
            tick();
        end
        in_valid = 1'b0;
        chk("full_out_valid", 32'(out_valid), 32'b111);
        chk("full_s1", 32'(S1), 32'h101);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_s0", 32'(S0), 32'd0);
        chk("async_rst_s1", 32'(S1), 32'd0);
        chk("async_rst_s2", 32'(S2), 32'd0);
        chk("async_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
